data_memory_mmio: RTL

Parametrised data-memory and memory-mapped I/O subsystem between the CPU load/store port and the VGA reader. Provides a true dual-port video RAM: port A for CPU read/write, port B read-only for video. Alongside it sit N button channels with synchronisers and sticky press flags, a sticky timer flag, and a bounded random-number register. All CPU reads are registered with uniform one-cycle latency.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/btn_capture.sv | 41 ++++
 rtl/data_memory_mmio.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Constants and types shared by the data-memory / memory-mapped I/O subsystem.
package dmem_pkg;

    localparam logic [31:0] DEF_RAM_BASE   = 32'h0000_6000;
    localparam logic [31:0] DEF_RAM_STRIDE = 32'h0000_1000;
    localparam logic [31:0] DEF_IO_BASE    = 32'h0000_2000;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 on a left-shifting register: XOR of bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int OFF_BTN0 = 0;

    function automatic int OFF_RAND(input int n_btn_ch);
        return 4 * n_btn_ch;
    endfunction

    function automatic int OFF_TIMER(input int n_btn_ch);
        return 4 * (n_btn_ch + 1);
    endfunction

    function automatic int OFF_ID(input int n_btn_ch);
        return 4 * (n_btn_ch + 2);
    endfunction

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_BTN,
        SEL_RAND,
        SEL_TIMER,
        SEL_ID
    } dmem_sel_e;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_capture.sv
// Two-flop synchroniser, rising-edge detect and write-1-to-clear sticky flags
// for a group of BTN_W asynchronous inputs.
module btn_capture #(
    parameter int BTN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] btn_i,
    input  logic [BTN_W-1:0] clr_i,
    output logic [BTN_W-1:0] level_o,
    output logic [BTN_W-1:0] sticky_o
);

    logic [BTN_W-1:0] meta_q;
    logic [BTN_W-1:0] level_q;
    logic [BTN_W-1:0] prev_q;
    logic [BTN_W-1:0] sticky_q;
    logic [BTN_W-1:0] sticky_d;

    // A set arriving together with a clear wins, so no press is ever lost.
    always_comb sticky_d = (sticky_q & ~clr_i) | (level_q & ~prev_q);

    // NOTE: non-blocking assignments make every flop sample its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= '0;
            level_q  <= '0;
            prev_q   <= '0;
            sticky_q <= '0;
        end else begin
            meta_q   <= btn_i;
            level_q  <= meta_q;
            prev_q   <= level_q;
            sticky_q <= sticky_d;
        end
    end

    assign level_o  = level_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/data_memory_mmio.sv
// CPU data memory: dual-port video RAM plus button, timer-flag, random and ID
// registers, all read with one cycle of latency.
module data_memory_mmio
    import dmem_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          RAM_DEPTH  = 8,
    parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
    parameter logic [31:0] RAM_STRIDE = DEF_RAM_STRIDE,
    parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
    parameter int          N_BTN_CH   = 2,
    parameter int          BTN_W      = 2,
    parameter int          RAND_MAX   = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               addr_A,
    input  logic [DATA_W-1:0]         WD,
    input  logic                      WE,
    input  logic [31:0]               addr_B,
    input  logic [N_BTN_CH*BTN_W-1:0] botones,
    input  logic                      time_up,
    output logic [DATA_W-1:0]         RD,
    output logic [DATA_W-1:0]         DataVideo
);

    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int IDX_W  = (RAM_AW > 3) ? RAM_AW : 3;
    localparam int NB     = N_BTN_CH * BTN_W;
    localparam logic [7:0]        RAND_MOD = 8'(RAND_MAX);
    localparam logic [DATA_W-1:0] ID_VALUE =
        DATA_W'((RAM_DEPTH << 16) | (N_BTN_CH << 8) | BTN_W);

    typedef struct packed {
        dmem_sel_e        sel;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Exact-match decode: only the listed addresses hit, so a RAM write never aliases to word 0.
    function automatic dec_t decode(input logic [31:0] addr);
        dec_t d;
        d.sel = SEL_NONE;
        d.idx = '0;
        for (int i = 0; i < RAM_DEPTH; i++) begin
            if (addr == RAM_BASE + 32'(i) * RAM_STRIDE) begin
                d.sel = SEL_RAM;
                d.idx = IDX_W'(i);
            end
        end
        for (int k = 0; k < N_BTN_CH; k++) begin
            if (addr == IO_BASE + 32'(OFF_BTN0 + 4 * k)) begin
                d.sel = SEL_BTN;
                d.idx = IDX_W'(k);
            end
        end
        if (addr == IO_BASE + 32'(OFF_RAND(N_BTN_CH)))  d.sel = SEL_RAND;
        if (addr == IO_BASE + 32'(OFF_TIMER(N_BTN_CH))) d.sel = SEL_TIMER;
        if (addr == IO_BASE + 32'(OFF_ID(N_BTN_CH)))    d.sel = SEL_ID;
        return d;
    endfunction

    dec_t dec_a;
    dec_t dec_b;

    always_comb dec_a = decode(addr_A);
    always_comb dec_b = decode(addr_B);

    // ---------------- video RAM ----------------
    logic              we_ram;
    logic [DATA_W-1:0] mem [RAM_DEPTH];
    logic [DATA_W-1:0] ram_a_q;
    logic [DATA_W-1:0] ram_b_q;

    assign we_ram = WE && (dec_a.sel == SEL_RAM);

    // NOTE: the array and its read registers have no reset; outputs are zeroed by the
    // registered select instead, and writes stay live while reset is asserted.
    always_ff @(posedge clk) begin
        if (we_ram) mem[dec_a.idx[RAM_AW-1:0]] <= WD;
        ram_a_q <= mem[dec_a.idx[RAM_AW-1:0]];
        ram_b_q <= mem[dec_b.idx[RAM_AW-1:0]];
    end

    // ---------------- buttons and timer flag ----------------
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_sticky;
    logic          tu_level;
    logic          tu_sticky;
    logic          tu_clr;

    for (genvar c = 0; c < N_BTN_CH; c++) begin : g_btn
        logic [BTN_W-1:0] clr;

        assign clr = (WE && dec_a.sel == SEL_BTN && dec_a.idx == IDX_W'(c))
                   ? WD[2*BTN_W-1:BTN_W] : '0;

        btn_capture #(.BTN_W(BTN_W)) u_btn (
            .clk     (clk),
            .rst_n   (reset),
            .btn_i   (botones[c*BTN_W +: BTN_W]),
            .clr_i   (clr),
            .level_o (btn_level[c*BTN_W +: BTN_W]),
            .sticky_o(btn_sticky[c*BTN_W +: BTN_W])
        );
    end

    assign tu_clr = WE && (dec_a.sel == SEL_TIMER) && WD[1];

    btn_capture #(.BTN_W(1)) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (time_up),
        .clr_i   (tu_clr),
        .level_o (tu_level),
        .sticky_o(tu_sticky)
    );

    // ---------------- random register ----------------
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] rand_q;
    logic [7:0] rand_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        rand_d = (lfsr_q % RAND_MOD) + 8'd1;
    end

    // ---------------- read path ----------------
    logic [DATA_W-1:0] io_d;
    logic [DATA_W-1:0] io_q;
    dmem_sel_e         sel_q;
    logic              b_hit_q;

    // NOTE: io_d gets a default first so no branch can leave it unassigned and infer a latch.
    always_comb begin
        io_d = '0;
        case (dec_a.sel)
            SEL_BTN: begin
                for (int k = 0; k < N_BTN_CH; k++) begin
                    if (dec_a.idx == IDX_W'(k))
                        io_d = DATA_W'({btn_sticky[k*BTN_W +: BTN_W], btn_level[k*BTN_W +: BTN_W]});
                end
            end
            SEL_RAND:  io_d = DATA_W'(rand_q);
            SEL_TIMER: io_d = DATA_W'({tu_sticky, tu_level});
            SEL_ID:    io_d = ID_VALUE;
            default:   io_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q   <= SEL_NONE;
            io_q    <= '0;
            b_hit_q <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            rand_q  <= (LFSR_SEED % RAND_MOD) + 8'd1;
        end else begin
            sel_q   <= dec_a.sel;
            io_q    <= io_d;
            b_hit_q <= (dec_b.sel == SEL_RAM);
            lfsr_q  <= lfsr_d;
            rand_q  <= rand_d;
        end
    end

    assign RD        = (sel_q == SEL_RAM) ? ram_a_q : io_q;
    assign DataVideo = b_hit_q ? ram_b_q : '0;

endmodule
